// File: rtl/canvas_pkg.sv
// Shared canvas types for the drawing-canvas blocks.
//   CANVAS_DIM     : canvas width and height in pixels
//   PIX_W          : pixel width in bits
//   pixel_t        : one canvas pixel
//   canvas_t       : full canvas, indexed [row][col]
//   stream_state_t : canvas_streamer FSM states
package canvas_pkg;

  localparam int unsigned CANVAS_DIM = 28;
  localparam int unsigned PIX_W      = 16;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t canvas_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0];

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} stream_state_t;

endpackage

// File: rtl/canvas_streamer.sv
// Walks the canvas in raster order and emits one pixel per valid/ready transfer.
// Each row is snapshotted into a local row buffer in a one-cycle LOAD state, so
// canvas writes landing mid-row never tear the row being streamed.
//
// Ports:
//   Clk, Reset_n  : clock, asynchronous active-low reset
//   Start         : request one full-image pass (sampled only in IDLE)
//   canvas        : live canvas, canvas[row][col]
//   Pix_data      : current pixel
//   Pix_row/col   : coordinates of Pix_data
//   Pix_valid     : pixel, coordinates and last flags are valid
//   Pix_ready     : consumer accepts the pixel
//   Row_last      : current pixel is at column DIM-1
//   Img_last      : current pixel is the final pixel of the image
//   Busy          : high from LOAD of row 0 through the last transfer
//   Done          : one-cycle pulse after the final transfer
//
// All outputs are registers; Pix_valid never depends on Pix_ready.
// Row/column indices are 5 bits wide, so DIM must not exceed 32.
module canvas_streamer #(
  parameter int unsigned DIM   = canvas_pkg::CANVAS_DIM,
  parameter int unsigned PIX_W = canvas_pkg::PIX_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PIX_W-1:0] canvas [DIM-1:0][DIM-1:0],
  output logic [PIX_W-1:0] Pix_data,
  output logic [4:0]       Pix_row,
  output logic [4:0]       Pix_col,
  output logic             Pix_valid,
  input  logic             Pix_ready,
  output logic             Row_last,
  output logic             Img_last,
  output logic             Busy,
  output logic             Done
);

  localparam logic [4:0] LastIdx = 5'(DIM - 1);

  canvas_pkg::stream_state_t state_q;

  logic [DIM-1:0][PIX_W-1:0] rowbuf_q;
  logic [4:0]                row_q;
  logic [4:0]                col_q;
  logic [PIX_W-1:0]          data_q;
  logic                      valid_q;
  logic                      row_last_q;
  logic                      img_last_q;
  logic                      busy_q;
  logic                      done_q;

  logic [4:0] col_inc;
  logic       next_is_last_col;

  always_comb begin
    col_inc          = col_q + 5'd1;
    next_is_last_col = (col_inc == LastIdx);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= canvas_pkg::S_IDLE;
      rowbuf_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      row_last_q <= 1'b0;
      img_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        canvas_pkg::S_IDLE: begin
          if (Start) begin
            state_q <= canvas_pkg::S_LOAD;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        canvas_pkg::S_LOAD: begin
          // Snapshot the whole row; later canvas writes to it stay invisible.
          for (int unsigned i = 0; i < DIM; i++) begin
            rowbuf_q[i] <= canvas[row_q][i];
          end
          data_q     <= canvas[row_q][0];
          col_q      <= '0;
          valid_q    <= 1'b1;
          row_last_q <= (DIM == 1);
          img_last_q <= (DIM == 1) && (row_q == LastIdx);
          state_q    <= canvas_pkg::S_STREAM;
        end

        canvas_pkg::S_STREAM: begin
          // valid_q is high for the whole of STREAM, so ready alone marks a transfer.
          if (Pix_ready) begin
            if (col_q != LastIdx) begin
              col_q      <= col_inc;
              data_q     <= rowbuf_q[col_inc];
              row_last_q <= next_is_last_col;
              img_last_q <= next_is_last_col && (row_q == LastIdx);
            end else begin
              valid_q    <= 1'b0;
              row_last_q <= 1'b0;
              img_last_q <= 1'b0;
              if (row_q != LastIdx) begin
                row_q   <= row_q + 5'd1;
                state_q <= canvas_pkg::S_LOAD;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= canvas_pkg::S_DONE;
              end
            end
          end
        end

        canvas_pkg::S_DONE: begin
          done_q  <= 1'b0;
          state_q <= canvas_pkg::S_IDLE;
        end

        default: begin
          state_q <= canvas_pkg::S_IDLE;
        end
      endcase
    end
  end

  assign Pix_data  = data_q;
  assign Pix_row   = row_q;
  assign Pix_col   = col_q;
  assign Pix_valid = valid_q;
  assign Row_last  = row_last_q;
  assign Img_last  = img_last_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_canvas_streamer.sv
// Scoreboard bench for canvas_streamer: stimulus pushes the expected raster
// sequence of each pass into a queue; a negedge monitor pops and compares
// every transfer and checks that stalled outputs hold.
module tb_canvas_streamer;
  import canvas_pkg::*;

  localparam int D = 28;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       Pix_ready = 1'b0;
  canvas_t    canvas;
  logic [15:0] Pix_data;
  logic [4:0] Pix_row, Pix_col;
  logic       Pix_valid, Row_last, Img_last, Busy, Done;

  always #5 Clk = ~Clk;

  canvas_streamer dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .canvas    (canvas),
    .Pix_data  (Pix_data),
    .Pix_row   (Pix_row),
    .Pix_col   (Pix_col),
    .Pix_valid (Pix_valid),
    .Pix_ready (Pix_ready),
    .Row_last  (Row_last),
    .Img_last  (Img_last),
    .Busy      (Busy),
    .Done      (Done)
  );

  typedef struct packed {
    logic [4:0]  row;
    logic [4:0]  col;
    logic [15:0] data;
    logic        rl;
    logic        il;
  } xfer_t;

  xfer_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_row = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) canvas[r][c] = 16'(r * D + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) canvas[r][c] = 16'($urandom);
  endtask

  // Reference: a pass is the current canvas in raster order with flags from coordinates.
  task automatic push_pass();
    xfer_t e;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        e.row  = 5'(r);
        e.col  = 5'(c);
        e.data = canvas[r][c];
        e.rl   = (c == D - 1);
        e.il   = (r == D - 1) && (c == D - 1);
        exp_q.push_back(e);
      end
  endtask

  // A canvas write is seen only by rows whose LOAD has not happened yet.
  task automatic model_write(input int r, input int c, input logic [15:0] v);
    canvas[r][c] = v;
    if (r > last_row)
      foreach (exp_q[i])
        if (exp_q[i].row == 5'(r) && exp_q[i].col == 5'(c)) exp_q[i].data = v;
  endtask

  // Monitor: outputs are sampled on the falling edge; valid&&ready here means
  // a transfer happens at the next rising edge.
  initial begin : monitor
    xfer_t act, held, e;
    bit stalled;
    stalled = 1'b0;
    forever begin
      @(negedge Clk);
      act = {Pix_row, Pix_col, Pix_data, Row_last, Img_last};
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (Reset_n && Pix_valid) begin
        if (stalled) check("hold_stable", 64'(act), 64'(held));
        if (Pix_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer: got %h, expected no transfer", act);
          end else begin
            e = exp_q.pop_front();
            check("xfer", 64'(act), 64'(e));
          end
          xfer_cnt++;
          last_row = int'(Pix_row);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = act;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic pulse_start(output int s_cyc);
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    s_cyc = cyc;  // index of the edge that sampled Start
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge Clk); #1;
      if (rnd) Pix_ready = 1'($urandom_range(0, 1));
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 64'(done_cnt), 64'(d0 + 1));
    Pix_ready = 1'b1;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (xfer_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk); #1;
    end
    if (!ok) check("xfer_timeout", 64'(xfer_cnt), 64'(target));
  endtask

  initial begin : stimulus
    int s, x0, d0, dc;
    fill_ramp();

    // Reset state
    #12;
    check("rst_valid", 64'(Pix_valid), 64'(0));
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_done", 64'(Done), 64'(0));
    check("rst_last", 64'({Row_last, Img_last}), 64'(0));
    check("rst_data", 64'(Pix_data), 64'(0));
    check("rst_idx", 64'({Pix_row, Pix_col}), 64'(0));
    @(negedge Clk) Reset_n = 1'b1;

    // Ramp image at full rate
    Pix_ready = 1'b1;
    x0 = xfer_cnt;
    push_pass();
    pulse_start(s);
    run_until_done(2000, 1'b0);
    // Start cycle and Done cycle both counted: Done lands 812 edges after Start is sampled.
    check("done_latency", 64'(done_cyc - s + 2), 64'(2 + D * (D + 1)));
    check("ramp_count", 64'(xfer_cnt - x0), 64'(D * D));
    check("ramp_queue", 64'(exp_q.size()), 64'(0));

    // Random image under random backpressure
    fill_random();
    x0 = xfer_cnt;
    push_pass();
    pulse_start(s);
    run_until_done(6000, 1'b1);
    check("bp_count", 64'(xfer_cnt - x0), 64'(D * D));
    check("bp_queue", 64'(exp_q.size()), 64'(0));

    // Mid-row canvas writes after (3,10) is transferred
    fill_ramp();
    x0 = xfer_cnt;
    push_pass();
    pulse_start(s);
    wait_xfers(x0 + 3 * D + 11, 400);
    model_write(3, 20, 16'hBEEF);
    model_write(5, 0, 16'h1234);
    run_until_done(2000, 1'b0);
    check("midrow_queue", 64'(exp_q.size()), 64'(0));
    fill_ramp();

    // Start pulse while busy is ignored
    x0 = xfer_cnt;
    d0 = done_cnt;
    push_pass();
    pulse_start(s);
    wait_xfers(x0 + 100, 400);
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    run_until_done(2000, 1'b0);
    repeat (20) @(posedge Clk);
    #1;
    check("busy_start_done", 64'(done_cnt - d0), 64'(1));
    check("busy_start_xfers", 64'(xfer_cnt - x0), 64'(D * D));
    check("busy_start_idle", 64'(Busy), 64'(0));

    // Start held through DONE launches a second pass
    d0 = done_cnt;
    push_pass();
    push_pass();
    @(posedge Clk); #1 Start = 1'b1;
    run_until_done(2000, 1'b0);
    dc = done_cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk); #1;
      if (cyc == dc + 1) check("hold_idle_gap", 64'(Busy), 64'(0));
      if (cyc == dc + 2) begin
        check("hold_restart", 64'(Busy), 64'(1));
        break;
      end
    end
    @(posedge Clk); #1 Start = 1'b0;
    run_until_done(2000, 1'b0);
    check("hold_done_count", 64'(done_cnt - d0), 64'(2));
    check("hold_queue", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset mid-pass
    x0 = xfer_cnt;
    push_pass();
    pulse_start(s);
    wait_xfers(x0 + 400, 1000);
    @(posedge Clk); #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(Pix_valid), 64'(0));
    check("mid_rst_busy", 64'(Busy), 64'(0));
    check("mid_rst_flags", 64'({Done, Row_last, Img_last}), 64'(0));
    check("mid_rst_data", 64'(Pix_data), 64'(0));
    exp_q.delete();
    @(negedge Clk) Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    x0 = xfer_cnt;
    push_pass();
    pulse_start(s);
    run_until_done(2000, 1'b0);
    check("post_rst_count", 64'(xfer_cnt - x0), 64'(D * D));
    check("post_rst_queue", 64'(exp_q.size()), 64'(0));

    // Idle quiet
    repeat (3) @(posedge Clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk); #1;
      check("idle_quiet", 64'({Pix_valid, Busy, Done}), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/canvas_streamer.md
# canvas_streamer

Read-side counterpart to `canvas_editor`. It walks the 28×28 drawing canvas in raster order and emits one 16-bit pixel per transfer on a valid/ready stream, so a sequential inference engine can consume the image without sampling the whole array combinationally. Each row is latched into a local row buffer before it is streamed, so a row is never torn by a canvas update that lands mid-row. The block sits between the canvas storage and the neural-network datapath.

## Interface
Parameters:
- `DIM`, 28: canvas width and height in pixels.
- `PIX_W`, 16: pixel width in bits.

Ports:
- `Clk`, in, 1: system clock (50 MHz domain).
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: request one full-image pass. Sampled only in IDLE.
- `canvas`, in, `PIX_W` × `DIM` × `DIM`: live canvas, indexed `canvas[row][col]`.
- `Pix_data`, out, `PIX_W`: current pixel.
- `Pix_row`, out, 5: row index of `Pix_data`.
- `Pix_col`, out, 5: column index of `Pix_data`.
- `Pix_valid`, out, 1: `Pix_data`, `Pix_row`, `Pix_col` and the last flags are valid.
- `Pix_ready`, in, 1: the consumer accepts the pixel.
- `Row_last`, out, 1: current pixel is at column `DIM-1`.
- `Img_last`, out, 1: current pixel is at row `DIM-1`, column `DIM-1`.
- `Busy`, out, 1: high from LOAD of row 0 through the last transfer.
- `Done`, out, 1: one-cycle pulse after the final transfer.

## Operation
- States: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - `Start`=1 → LOAD with `row`=0.
  - Otherwise stay in IDLE.
- LOAD (one cycle):
  - Copy `canvas[row][0..DIM-1]` into the row buffer.
  - Set `col`=0, then go to STREAM.
- STREAM:
  - `Pix_valid`=1, `Pix_data`=rowbuf[`col`].
  - A transfer occurs on `Pix_valid && Pix_ready`. On a transfer:
    - `col` < `DIM-1`: `col`++ and stay in STREAM.
    - `col` = `DIM-1` and `row` < `DIM-1`: `row`++ and go to LOAD.
    - `col` = `DIM-1` and `row` = `DIM-1`: go to DONE.
- DONE (one cycle): `Done`=1, then go to IDLE.
- `Start` is ignored outside IDLE. A `Start` held high through DONE launches a new pass from the following IDLE cycle.
- Canvas changes after a row's LOAD are invisible until that row's next pass. Rows not yet loaded reflect the canvas contents at their own LOAD cycle.
- Reset values (asynchronous, immediate, including mid-pass):
  - State IDLE, `row`=`col`=0.
  - `Pix_valid`=`Busy`=`Done`=0, `Row_last`=`Img_last`=0, `Pix_data`=0.
  - Row buffer cleared to 0.
  - No partial pass resumes after reset.

## Timing
- `Start` sampled high at edge k → LOAD at cycle k+1 → first `Pix_valid` at cycle k+2.
- Outputs are registered or decoded from registered state only. `Pix_valid` never depends combinationally on `Pix_ready`.
- While `Pix_valid`=1 and `Pix_ready`=0, `Pix_data`, `Pix_row`, `Pix_col`, `Row_last` and `Img_last` hold stable.
- Each row boundary inserts exactly one LOAD bubble cycle with `Pix_valid`=0.
- With `Pix_ready` held at 1: Start→Done = 2 + `DIM`·(`DIM`+1) cycles, i.e. 814 cycles for `DIM`=28.
- `Busy` falls in the DONE cycle, the same cycle `Done` is high.
- Index widths: 5 bits covers `DIM` ≤ 32. `DIM` > 32 is unsupported.

## Structure
- Shared package `canvas_pkg`:
  - `CANVAS_DIM`=28, `PIX_W`=16.
  - `typedef logic [PIX_W-1:0] pixel_t`.
  - `typedef pixel_t canvas_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0]`.
  - `typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} stream_state_t`.
  - `canvas_editor`, `color_mapper` and `neural_network` migrate to `canvas_t`.
- Single module, no sub-module. The row buffer is an internal `pixel_t [DIM-1:0]` register.

## Test plan
- **Ramp image, full-rate pass:** `canvas[r][c]` = `r*28+c`, `Pix_ready`=1, one-cycle `Start`.
  - Expect 784 transfers in order with `Pix_data` = 0..783.
  - `Row_last` on every 28th transfer; `Img_last` only on value 783.
  - `Done` exactly 814 cycles after `Start`.
- **Backpressure:** random `Pix_ready` with 50% duty.
  - Transfer sequence identical to the full-rate pass.
  - Data and flags stable during every stalled cycle.
- **Mid-row canvas write:** during row 3, col 10, write `canvas[3][20]`=`16'hBEEF` and `canvas[5][0]`=`16'h1234`.
  - Streamed (3,20) keeps its old value.
  - Streamed (5,0) = `16'h1234`.
- **Start while busy:** pulse `Start` at transfer 100. Expect no restart and one `Done`. Holding `Start`=1 through DONE yields a second pass beginning 2 cycles after `Done`.
- **Reset mid-pass:** assert `Reset_n`=0 at transfer 400.
  - Outputs are 0 asynchronously.
  - After release plus `Start`, the stream restarts at (0,0) with value 0.
- **Idle quiet:** `Start`=0 for 1000 cycles. `Pix_valid`, `Busy` and `Done` stay 0.
